// File: rtl/tv_recorder.sv
// Test-vector capture engine: records a window of per-cycle samples into an
// internal memory, then replays them in order over a ready/valid port.
module tv_recorder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 9,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [AW-1:0]    count,
  output logic             done,
  output logic             ovf
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READ
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [AW-1:0]    count_inc;
  logic             mem_we;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    count_inc = count_q + (sample_valid ? ONE : '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
          count_d  = count_inc;
        end
        // A sample arriving with stop is kept, so the empty check uses count_inc
        if (count_inc == DEPTH_C) begin
          state_d = READ;
        end else if (stop) begin
          if (count_inc != '0) begin
            state_d = READ;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (sample_valid) begin
          ovf_d = 1'b1;
        end
        if (out_ready) begin
          if ((rd_ptr_q + ONE) == count_q) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Capture memory has no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[wr_ptr_q[IW-1:0]] <= sample_data;
    end
  end

  // Outputs are forced low while rst is asserted, even before the first edge
  assign out_valid = rst && (state_q == READ);
  assign out_data  = out_valid ? mem[rd_ptr_q[IW-1:0]] : '0;
  assign busy      = rst && (state_q != IDLE);
  assign count     = rst ? count_q : '0;
  assign done      = rst && done_q;
  assign ovf       = rst && ovf_q;

endmodule

// File: tb/tb_tv_recorder.sv
// Self-checking bench for tv_recorder: randomized capture windows, with a
// queue scoreboard drained by an independent readout monitor.
module tb_tv_recorder;

  localparam int WIDTH = 4;
  localparam int DEPTH = 9;
  localparam int AW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample_data = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [AW-1:0]    count;
  logic             done;
  logic             ovf;

  int               tests = 0;
  int               fails = 0;
  int               cycle = 0;
  int               last_hs_cycle = -10;
  int               ready_mode = 0;
  int               ready_idx = 0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  tv_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .count        (count),
    .done         (done),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic sv,
                               input logic [WIDTH-1:0] d);
    start        = st;
    stop         = sp;
    sample_valid = sv;
    sample_data  = d;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " count"}, count, 0);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out_data"}, out_data, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " ovf"}, ovf, 0);
  endtask

  // Consumer side: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ready_idx % 4 == 0) || (ready_idx % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ready_idx++;
    end
  end

  // Monitor: every presented word must be the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("valid held while stalled", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected out_valid", out_valid, 0);
        end else begin
          checkOutput("out_data", out_data, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            last_hs_cycle = cycle;
          end
        end
      end else begin
        checkOutput("out_data zero when idle", out_data, 0);
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  // One complete window: start, n samples (random gaps), optional stop on the
  // last sample, then readout with optional ovf pokes and ignored start/stop.
  task automatic runWindow(input int n, input bit early_stop, input int ovf_extra,
                           input int max_gap, input bit seq, input int base);
    logic [WIDTH-1:0] d;
    bit               first;
    bit               got_done;
    int               gaps;

    applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
    tick();
    first = 1'b1;

    if (n == 0) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      checkOutput("empty busy", busy, 1);
      checkOutput("empty ovf cleared", ovf, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOutput("empty done", done, 1);
      checkOutput("empty busy after", busy, 0);
      checkOutput("empty count", count, 0);
      checkOutput("empty out_valid", out_valid, 0);
      tick();
      @(negedge clk);
      checkOutput("empty done one cycle", done, 0);
      tick();
      return;
    end

    for (int i = 0; i < n; i++) begin
      gaps = int'($urandom_range(0, max_gap));
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, WIDTH'($urandom));
        if (first) begin
          @(negedge clk);
          checkOutput("capture busy", busy, 1);
          checkOutput("capture count start", count, 0);
          checkOutput("start clears ovf", ovf, 0);
          first = 1'b0;
        end
        tick();
      end
      d = seq ? WIDTH'(base + i) : WIDTH'($urandom);
      applyStimulus(1'b0, early_stop && (i == n - 1), 1'b1, d);
      exp_q.push_back(d);
      if (first) begin
        @(negedge clk);
        checkOutput("capture busy", busy, 1);
        checkOutput("capture count start", count, 0);
        checkOutput("start clears ovf", ovf, 0);
        first = 1'b0;
      end
      tick();
    end

    got_done = 1'b0;
    for (int k = 0; k < 400 && !got_done; k++) begin
      applyStimulus((exp_q.size() >= 2) ? 1'($urandom_range(0, 1)) : 1'b0,
                    1'($urandom_range(0, 1)), (k < ovf_extra), WIDTH'($urandom));
      @(negedge clk);
      if (k == 0) checkOutput("first word latency", out_valid, 1);
      if (done) begin
        got_done = 1'b1;
        checkOutput("done timing", cycle, last_hs_cycle + 1);
        checkOutput("words left at done", exp_q.size(), 0);
        checkOutput("busy at done", busy, 0);
        checkOutput("count at done", count, n);
        checkOutput("ovf at done", ovf, (ovf_extra > 0) ? 1 : 0);
        checkOutput("out_valid at done", out_valid, 0);
      end
      tick();
    end
    checkOutput("done seen", got_done, 1);
    if (!got_done) exp_q.delete();

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("done one cycle", done, 0);
    checkOutput("count held", count, n);
    tick();
  endtask

  task automatic resetMidCapture();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'($urandom));
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, WIDTH'($urandom));
    @(negedge clk);
    checkAllZero("in mid reset");
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("post reset busy", busy, 0);
    checkOutput("post reset count", count, 0);
    checkOutput("post reset out_valid", out_valid, 0);
    checkOutput("post reset done", done, 0);
    tick();
  endtask

  initial begin
    int n;
    int ox;
    bit es;

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    @(negedge clk);
    checkAllZero("in reset");
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("after reset");
    tick();

    ready_mode = 0;
    runWindow(DEPTH, 1'b0, 0, 0, 1'b1, 0);
    runWindow(3, 1'b1, 0, 0, 1'b1, 10);

    ready_mode = 1;
    runWindow(DEPTH, 1'b0, 0, 0, 1'b1, 0);

    ready_mode = 0;
    runWindow(0, 1'b1, 0, 0, 1'b0, 0);
    runWindow(DEPTH, 1'b0, 2, 0, 1'b0, 0);
    @(negedge clk);
    checkOutput("ovf sticky in idle", ovf, 1);
    tick();

    resetMidCapture();
    runWindow(2, 1'b1, 0, 0, 1'b1, 5);

    for (int w = 0; w < 12; w++) begin
      ready_mode = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, DEPTH));
      es = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      ox = int'($urandom_range(0, (n < 2) ? n : 2));
      runWindow(n, es, ox, 2, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tv_recorder.md
# tv_recorder

Synthesizable test-vector capture engine: records a window of per-cycle samples (DUT inputs concatenated with DUT output) into an internal memory, then streams them back out in order over a ready/valid port. It is the writer counterpart of our vector-driven benches. It captures golden vectors from a known-good MIPS datapath block, and the readout is dumped to `.tv` files in the same bit layout the benches load.

## Interface
- WIDTH, 4: bits per sample, e.g. {d0,d1,s,y}.
- DEPTH, 9: capture memory entries (max samples per window), ≥1.
- AW, $clog2(DEPTH+1): width of pointers and count.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; arms a new capture window.
- stop  in  1  ends capture early.
- sample_valid  in  1  sample_data is written this cycle.
- sample_data  in  WIDTH  sample to record.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds a recorded sample.
- out_data  out  WIDTH  recorded sample; 0 when out_valid=0.
- busy  out  1  state is CAPTURE or READ.
- count  out  AW  samples recorded in the current or last window.
- done  out  1  one-cycle pulse when a window finishes (readout complete or empty window).
- ovf  out  1  sticky; sample_valid seen while the window was full.

## Operation
- States: IDLE, CAPTURE, READ. Registers: wr_ptr, rd_ptr, count, ovf, state, mem[DEPTH].
- Reset (rst=0 at edge) sets state=IDLE, wr_ptr=rd_ptr=count=0, ovf=0, done=0. Memory contents are not cleared. All outputs read 0 while in reset.
- IDLE:
  - start=1 → CAPTURE; wr_ptr=0, count=0, ovf=0.
  - sample_valid is ignored and does not set ovf.
- CAPTURE:
  - sample_valid=1 → mem[wr_ptr]=sample_data, wr_ptr+1, count+1.
  - After the write that makes count==DEPTH → READ.
  - stop=1 → leave CAPTURE. A sample presented in the same cycle is still written. With count (after any write) ≥1 → READ; with count 0 → IDLE with done=1.
  - start is ignored.
- READ:
  - out_valid=1 and out_data=mem[rd_ptr] (combinational read).
  - Handshake out_valid&out_ready → rd_ptr+1.
  - Handshake on rd_ptr==count-1 → IDLE, done=1 the next cycle, rd_ptr=0.
  - sample_valid=1 → ovf=1 (sample dropped).
  - start and stop are ignored.
- count holds its value after the window, until the next start or reset.
- out_data must not change while out_valid=1 and out_ready=0.

## Timing
- start sampled at edge n → busy=1 from n+1. The first sample is accepted at edge n+1 or later.
- Capture throughput: 1 sample/cycle, no bubbles.
- The write at edge m fills the window (or stop at m) → out_valid=1 in the cycle after m, with out_data=first sample.
- Readout throughput: 1 word/cycle with out_ready held high. A full window of N samples drains in N cycles.
- done is registered: it is high for exactly the cycle after the final handshake (or after an empty stop). busy=0 in that same cycle.
- Reset mid-CAPTURE or mid-READ: next cycle IDLE, out_valid=0, count=0, no done pulse.
- start coincident with the final READ handshake is ignored; start must be re-issued from IDLE.

## Test plan
- Full window, DEPTH=9, WIDTH=4: start, then 9 consecutive samples 4'h0..4'h8; out_ready=1 → out_data 0..8 in order over 9 cycles, count=9, done pulse one cycle after word 8, ovf=0.
- Early stop: 3 samples 4'hA,4'hB,4'hC, with stop asserted alongside 4'hC → readout A,B,C only, count=3, done after C.
- Backpressure: window of 0..8, out_ready toggled 1,0,0,1,… → every word appears exactly once in order, out_data stable while stalled, no word skipped or repeated.
- Empty stop: start, then stop with sample_valid=0 on the first CAPTURE cycle → never READ, out_valid stays 0, done pulse, count=0.
- Overflow: fill 9 samples, then sample_valid=1 for 2 cycles during READ → ovf=1, readout still 9 original words. A new start clears ovf to 0.
- Reset mid-operation: rst=0 for one cycle after 4 samples → busy=0, count=0, out_valid=0, no done. A fresh 2-sample window then reads back correctly.
